// File: rtl/multdiv_sequencer_if.sv
// Purpose: bundles the execute-request, multiply/divide-unit and writeback signals of the sequencer.
// Latency: none, wiring only.
// Backpressure: req uses req_valid/req_ready, writeback uses wb_valid/wb_ready, the unit uses a start pulse plus resultRDY.
// Ports: slave = sequencer view, master = pipeline/unit environment view.
interface multdiv_sequencer_if #(
    parameter int TAG_W = 5
);
    logic              req_valid;
    logic              req_is_div;
    logic [31:0]       req_opA;
    logic [31:0]       req_opB;
    logic [TAG_W-1:0]  req_tag;
    logic              req_ready;
    logic              flush;
    logic              busy;
    logic              md_ctrl_MULT;
    logic              md_ctrl_DIV;
    logic [31:0]       md_operandA;
    logic [31:0]       md_operandB;
    logic [31:0]       md_result;
    logic              md_exception;
    logic              md_resultRDY;
    logic              wb_valid;
    logic [TAG_W-1:0]  wb_tag;
    logic [31:0]       wb_data;
    logic              wb_exception;
    logic              wb_ready;
    logic              timeout_err;

    modport slave (
        input  req_valid, req_is_div, req_opA, req_opB, req_tag, flush,
        input  md_result, md_exception, md_resultRDY, wb_ready,
        output req_ready, busy, md_ctrl_MULT, md_ctrl_DIV, md_operandA, md_operandB,
        output wb_valid, wb_tag, wb_data, wb_exception, timeout_err
    );

    modport master (
        output req_valid, req_is_div, req_opA, req_opB, req_tag, flush,
        output md_result, md_exception, md_resultRDY, wb_ready,
        input  req_ready, busy, md_ctrl_MULT, md_ctrl_DIV, md_operandA, md_operandB,
        input  wb_valid, wb_tag, wb_data, wb_exception, timeout_err
    );
endinterface

// File: rtl/multdiv_sequencer.sv
// Purpose: sequences one multiply/divide op at a time through the shared iterative unit.
// Latency: accept edge N -> start pulse in the following cycle; unit RDY k cycles after the pulse -> wb_valid k+1 cycles after the pulse; divide-by-zero -> wb_valid right after accept.
// Backpressure: req_ready only in IDLE; the result is held in DONE until wb_ready; flush aborts any in-flight op.
// Ports: clock, reset_n (sync, active low), bus (multdiv_sequencer_if.slave: request, unit and writeback channels).
module multdiv_sequencer #(
    parameter int TIMEOUT = 40,
    parameter int TAG_W   = 5
) (
    input  logic                 clock,
    input  logic                 reset_n,
    multdiv_sequencer_if.slave   bus
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        opa_q, opa_d;
    logic [31:0]        opb_q, opb_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic               is_div_q, is_div_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [31:0]        wb_data_q, wb_data_d;
    logic               wb_exc_q, wb_exc_d;
    logic               timeout_err_q, timeout_err_d;
    logic               accept;

    // A flush in IDLE suppresses acceptance for that cycle.
    assign accept = bus.req_valid & bus.req_ready & ~bus.flush;

    always_comb begin
        state_d       = state_q;
        opa_d         = opa_q;
        opb_d         = opb_q;
        tag_d         = tag_q;
        is_div_d      = is_div_q;
        count_d       = count_q;
        wb_data_d     = wb_data_q;
        wb_exc_d      = wb_exc_q;
        timeout_err_d = timeout_err_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    opa_d     = bus.req_opA;
                    opb_d     = bus.req_opB;
                    tag_d     = bus.req_tag;
                    is_div_d  = bus.req_is_div;
                    wb_data_d = 32'd0;
                    wb_exc_d  = 1'b0;
                    // Divide by zero never reaches the unit: report it directly.
                    if (bus.req_is_div && (bus.req_opB == 32'd0)) begin
                        wb_exc_d = 1'b1;
                        state_d  = DONE;
                    end else begin
                        state_d  = START;
                    end
                end
            end
            START: begin
                // resultRDY is deliberately ignored here; it may belong to an aborted op.
                count_d = '0;
                state_d = bus.flush ? IDLE : WAIT;
            end
            WAIT: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (bus.md_resultRDY) begin
                    wb_data_d = bus.md_result;
                    wb_exc_d  = bus.md_exception;
                    state_d   = DONE;
                end else if (count_q == CNT_W'(TIMEOUT - 1)) begin
                    wb_data_d     = 32'd0;
                    wb_exc_d      = 1'b1;
                    timeout_err_d = 1'b1;
                    state_d       = DONE;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (bus.flush || bus.wb_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            opa_q         <= 32'd0;
            opb_q         <= 32'd0;
            tag_q         <= '0;
            is_div_q      <= 1'b0;
            count_q       <= '0;
            wb_data_q     <= 32'd0;
            wb_exc_q      <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            opa_q         <= opa_d;
            opb_q         <= opb_d;
            tag_q         <= tag_d;
            is_div_q      <= is_div_d;
            count_q       <= count_d;
            wb_data_q     <= wb_data_d;
            wb_exc_q      <= wb_exc_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Start pulses are decoded from the one-cycle START state, so they can never overlap.
    assign bus.req_ready    = (state_q == IDLE) & reset_n;
    assign bus.busy         = (state_q != IDLE);
    assign bus.md_ctrl_MULT = (state_q == START) & ~is_div_q;
    assign bus.md_ctrl_DIV  = (state_q == START) &  is_div_q;
    assign bus.md_operandA  = opa_q;
    assign bus.md_operandB  = opb_q;
    assign bus.wb_valid     = (state_q == DONE);
    assign bus.wb_tag       = tag_q;
    assign bus.wb_data      = wb_data_q;
    assign bus.wb_exception = wb_exc_q;
    assign bus.timeout_err  = timeout_err_q;
endmodule

// File: tb/tb_multdiv_sequencer.sv
// Purpose: self-checking bench for multdiv_sequencer with a behavioural multiply/divide unit and reference arithmetic.
// Latency: expected wb_valid timing derived from accept edge and unit latency.
// Backpressure: exercises wb_ready stalls, flush aborts, timeouts and mid-op reset.
module tb_multdiv_sequencer;
    localparam int TIMEOUT = 40;
    localparam int TAG_W   = 5;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    multdiv_sequencer_if #(.TAG_W(TAG_W)) mif();

    multdiv_sequencer #(.TIMEOUT(TIMEOUT), .TAG_W(TAG_W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (mif)
    );

    int checks   = 0;
    int failures = 0;
    int edge_cnt = 0;
    always @(posedge clock) edge_cnt++;

    // Reference arithmetic: signed 32-bit multiply (low word) and signed divide.
    function automatic void ref_op(input bit d, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic e);
        if (!d) begin
            r = a * b;
            e = 1'b0;
        end else if (b == 32'd0) begin
            r = 32'd0;
            e = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = 32'h8000_0000;
            e = 1'b1;
        end else begin
            r = 32'($signed(a) / $signed(b));
            e = 1'b0;
        end
    endfunction

    // Behavioural unit: answers k cycles after each start pulse (never if k < 0).
    bit          unit_auto = 1'b1;
    int          unit_lat  = 32;
    int          pend      = -1;
    logic        auto_rdy  = 1'b0;
    logic [31:0] auto_res  = 32'd0;
    logic        auto_exc  = 1'b0;
    logic        man_rdy   = 1'b0;
    logic [31:0] man_res   = 32'd0;
    logic        man_exc   = 1'b0;
    logic [31:0] u_a, u_b;
    bit          u_div;
    int          mult_pulses = 0;
    int          div_pulses  = 0;
    int          both_pulses = 0;

    assign mif.md_resultRDY = unit_auto ? auto_rdy : man_rdy;
    assign mif.md_result    = unit_auto ? auto_res : man_res;
    assign mif.md_exception = unit_auto ? auto_exc : man_exc;

    always @(negedge clock) begin
        auto_rdy = 1'b0;
        if (mif.md_ctrl_MULT === 1'b1) mult_pulses++;
        if (mif.md_ctrl_DIV === 1'b1) div_pulses++;
        if (mif.md_ctrl_MULT === 1'b1 && mif.md_ctrl_DIV === 1'b1) both_pulses++;
        if (mif.md_ctrl_MULT === 1'b1 || mif.md_ctrl_DIV === 1'b1) begin
            u_a   = mif.md_operandA;
            u_b   = mif.md_operandB;
            u_div = mif.md_ctrl_DIV;
            pend  = unit_lat;
        end else if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                ref_op(u_div, u_a, u_b, auto_res, auto_exc);
                auto_rdy = 1'b1;
                pend     = -1;
            end
        end
    end

    task automatic idle_inputs();
        mif.req_valid  = 1'b0;
        mif.req_is_div = 1'b0;
        mif.req_opA    = 32'd0;
        mif.req_opB    = 32'd0;
        mif.req_tag    = '0;
        mif.flush      = 1'b0;
        mif.wb_ready   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    // Presents one request; returns at the negedge after the accepting edge.
    task automatic send(input bit d, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] t, output int acc_edge);
        int w = 0;
        @(negedge clock);
        while (mif.req_ready !== 1'b1 && w < 200) begin
            @(negedge clock);
            w++;
        end
        checks++;
        if (mif.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL send_ready: req_ready=%b required 1", mif.req_ready);
        end
        mif.req_valid  = 1'b1;
        mif.req_is_div = d;
        mif.req_opA    = a;
        mif.req_opB    = b;
        mif.req_tag    = t;
        @(negedge clock);
        acc_edge      = edge_cnt;
        mif.req_valid = 1'b0;
    endtask

    // Waits (bounded) for wb_valid; also checks operands stay stable while the op is in flight.
    task automatic wait_wb(input int limit, input logic [31:0] ea, input logic [31:0] eb,
                           output int seen);
        int w   = 0;
        int bad = 0;
        seen = -1;
        while (w < limit) begin
            if (mif.wb_valid === 1'b1) begin
                seen = edge_cnt;
                break;
            end
            if (mif.md_operandA !== ea || mif.md_operandB !== eb) bad++;
            @(negedge clock);
            w++;
        end
        checks++;
        if (seen < 0 || bad != 0) begin
            failures++;
            $display("FAIL wait_wb: seen_edge=%0d operand_glitches=%0d required valid within %0d cycles and 0 glitches",
                     seen, bad, limit);
        end
    endtask

    // Completes the writeback handshake and checks the handoff/return to IDLE.
    task automatic consume();
        mif.wb_ready = 1'b1;
        checks++;
        if (mif.req_ready !== 1'b0) begin
            failures++;
            $display("FAIL handoff_req_ready: got %b required 0", mif.req_ready);
        end
        @(negedge clock);
        mif.wb_ready = 1'b0;
        checks++;
        if (mif.wb_valid !== 1'b0 || mif.busy !== 1'b0 || mif.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL after_consume: wb_valid=%b busy=%b req_ready=%b required 0 0 1",
                     mif.wb_valid, mif.busy, mif.req_ready);
        end
    endtask

    task automatic check_result(input string name, input logic [31:0] ed, input logic ee,
                                input logic [TAG_W-1:0] et);
        checks++;
        if (mif.wb_data !== ed || mif.wb_exception !== ee || mif.wb_tag !== et) begin
            failures++;
            $display("FAIL %s: data=%h exc=%b tag=%0d required data=%h exc=%b tag=%0d",
                     name, mif.wb_data, mif.wb_exception, mif.wb_tag, ed, ee, et);
        end
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset_n = 1'b0;
        idle_inputs();
        #1;
        checks++;
        if (mif.req_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_req_ready_low: got %b required 0", mif.req_ready);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        checks++;
        if (mif.req_ready !== 1'b1 || mif.busy !== 1'b0 || mif.wb_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: req_ready=%b busy=%b wb_valid=%b required 1 0 0",
                     mif.req_ready, mif.busy, mif.wb_valid);
        end
        checks++;
        if (mif.md_ctrl_MULT !== 1'b0 || mif.md_ctrl_DIV !== 1'b0 || mif.md_operandA !== 32'd0 ||
            mif.md_operandB !== 32'd0 || mif.timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_unit_side: mult=%b div=%b opA=%h opB=%h terr=%b required all 0",
                     mif.md_ctrl_MULT, mif.md_ctrl_DIV, mif.md_operandA, mif.md_operandB, mif.timeout_err);
        end
        check_result("reset_wb", 32'd0, 1'b0, '0);
    endtask

    task automatic test_mult();
        int acc, seen, mp0, dp0;
        unit_lat = 32;
        mp0 = mult_pulses;
        dp0 = div_pulses;
        send(1'b0, 32'd7, 32'hFFFF_FFFD, 5'd13, acc);
        checks++;
        if (mif.md_ctrl_MULT !== 1'b1 || mif.md_ctrl_DIV !== 1'b0) begin
            failures++;
            $display("FAIL mult_pulse_cycle: mult=%b div=%b required 1 0", mif.md_ctrl_MULT, mif.md_ctrl_DIV);
        end
        wait_wb(100, 32'd7, 32'hFFFF_FFFD, seen);
        checks++;
        if (seen != acc + 33) begin
            failures++;
            $display("FAIL mult_latency: wb edge=%0d required %0d", seen, acc + 33);
        end
        check_result("mult_result", 32'hFFFF_FFEB, 1'b0, 5'd13);
        checks++;
        if (mult_pulses - mp0 != 1 || div_pulses != dp0) begin
            failures++;
            $display("FAIL mult_pulse_count: mult=%0d div=%0d required 1 0", mult_pulses - mp0, div_pulses - dp0);
        end
        consume();
    endtask

    task automatic test_divzero();
        int acc, seen, dp0;
        unit_lat = 5;
        dp0 = div_pulses;
        send(1'b1, 32'd100, 32'd0, 5'd3, acc);
        checks++;
        if (mif.md_ctrl_DIV !== 1'b0) begin
            failures++;
            $display("FAIL divzero_no_pulse: div=%b required 0", mif.md_ctrl_DIV);
        end
        wait_wb(10, 32'd100, 32'd0, seen);
        checks++;
        if (seen != acc) begin
            failures++;
            $display("FAIL divzero_latency: wb edge=%0d required %0d", seen, acc);
        end
        check_result("divzero_result", 32'd0, 1'b1, 5'd3);
        consume();
        checks++;
        if (div_pulses != dp0) begin
            failures++;
            $display("FAIL divzero_pulse_count: got %0d required 0", div_pulses - dp0);
        end
    endtask

    task automatic test_backpressure();
        int acc, seen;
        unit_lat = 5;
        send(1'b1, 32'd100, 32'd7, 5'd9, acc);
        wait_wb(50, 32'd100, 32'd7, seen);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (mif.wb_valid !== 1'b1 || mif.wb_data !== 32'd14 || mif.req_ready !== 1'b0 ||
                mif.busy !== 1'b1 || mif.wb_tag !== 5'd9) begin
                failures++;
                $display("FAIL stall_hold[%0d]: valid=%b data=%0d rdy=%b busy=%b tag=%0d required 1 14 0 1 9",
                         i, mif.wb_valid, mif.wb_data, mif.req_ready, mif.busy, mif.wb_tag);
            end
            @(negedge clock);
        end
        consume();
    endtask

    task automatic test_flush();
        int acc, dp0;
        unit_auto = 1'b0;
        man_rdy   = 1'b0;
        dp0 = div_pulses;
        send(1'b1, 32'd555, 32'd5, 5'd2, acc);
        repeat (11) @(negedge clock);
        mif.flush = 1'b1;
        @(negedge clock);
        mif.flush = 1'b0;
        checks++;
        if (mif.busy !== 1'b0 || mif.wb_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_abort: busy=%b wb_valid=%b required 0 0", mif.busy, mif.wb_valid);
        end
        send(1'b1, 32'd100, 32'd7, 5'd4, acc);
        // Stale answer from the aborted op lands during START.
        man_rdy = 1'b1;
        man_res = 32'hDEAD_BEEF;
        man_exc = 1'b1;
        @(negedge clock);
        man_rdy = 1'b0;
        checks++;
        if (mif.wb_valid !== 1'b0 || mif.busy !== 1'b1) begin
            failures++;
            $display("FAIL stale_rdy_ignored: wb_valid=%b busy=%b required 0 1", mif.wb_valid, mif.busy);
        end
        repeat (2) @(negedge clock);
        man_rdy = 1'b1;
        man_res = 32'd14;
        man_exc = 1'b0;
        @(negedge clock);
        man_rdy = 1'b0;
        checks++;
        if (mif.wb_valid !== 1'b1) begin
            failures++;
            $display("FAIL flush_next_valid: got %b required 1", mif.wb_valid);
        end
        check_result("flush_next_result", 32'd14, 1'b0, 5'd4);
        consume();
        checks++;
        if (div_pulses - dp0 != 2) begin
            failures++;
            $display("FAIL flush_pulse_count: got %0d required 2", div_pulses - dp0);
        end
        unit_auto = 1'b1;
    endtask

    task automatic test_timeout();
        int acc, seen;
        checks++;
        if (mif.timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL timeout_err_pre: got %b required 0", mif.timeout_err);
        end
        unit_lat = -1;
        send(1'b0, 32'd3, 32'd4, 5'd21, acc);
        wait_wb(100, 32'd3, 32'd4, seen);
        checks++;
        if (seen != acc + TIMEOUT + 1) begin
            failures++;
            $display("FAIL timeout_latency: wb edge=%0d required %0d", seen, acc + TIMEOUT + 1);
        end
        check_result("timeout_result", 32'd0, 1'b1, 5'd21);
        checks++;
        if (mif.timeout_err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_err_set: got %b required 1", mif.timeout_err);
        end
        consume();
        unit_lat = 3;
        send(1'b0, 32'd6, 32'd9, 5'd1, acc);
        wait_wb(50, 32'd6, 32'd9, seen);
        check_result("post_timeout_result", 32'd54, 1'b0, 5'd1);
        consume();
        checks++;
        if (mif.timeout_err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_err_sticky: got %b required 1", mif.timeout_err);
        end
    endtask

    task automatic test_reset_mid();
        int acc, seen, p0;
        unit_lat = 30;
        send(1'b1, 32'd1000, 32'd10, 5'd7, acc);
        repeat (5) @(negedge clock);
        p0 = mult_pulses + div_pulses;
        reset_n = 1'b0;
        @(negedge clock);
        checks++;
        if (mif.busy !== 1'b0 || mif.wb_valid !== 1'b0 || mif.md_operandA !== 32'd0 ||
            mif.md_operandB !== 32'd0 || mif.timeout_err !== 1'b0 || mif.req_ready !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_state: busy=%b valid=%b opA=%h opB=%h terr=%b rdy=%b required 0 0 0 0 0 0",
                     mif.busy, mif.wb_valid, mif.md_operandA, mif.md_operandB, mif.timeout_err, mif.req_ready);
        end
        check_result("mid_reset_wb", 32'd0, 1'b0, '0);
        reset_n = 1'b1;
        checks++;
        if (mult_pulses + div_pulses != p0) begin
            failures++;
            $display("FAIL mid_reset_no_pulse: got %0d pulses required 0", mult_pulses + div_pulses - p0);
        end
        unit_lat = 4;
        send(1'b0, 32'd6, 32'd7, 5'd30, acc);
        wait_wb(50, 32'd6, 32'd7, seen);
        checks++;
        if (seen != acc + 5) begin
            failures++;
            $display("FAIL mid_reset_next_latency: wb edge=%0d required %0d", seen, acc + 5);
        end
        check_result("mid_reset_next_result", 32'd42, 1'b0, 5'd30);
        consume();
    endtask

    task automatic test_random();
        int acc, seen, lat, exp_edge;
        bit d;
        logic [31:0] a, b, er;
        logic ee;
        logic [TAG_W-1:0] t;
        for (int n = 0; n < 25; n++) begin
            d   = 1'($urandom_range(0, 1));
            a   = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 1000));
            b   = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 50));
            if (d && $urandom_range(0, 3) == 0) b = 32'd0;
            t   = TAG_W'($urandom);
            lat = $urandom_range(1, 20);
            unit_lat = lat;
            ref_op(d, a, b, er, ee);
            exp_edge = 0;
            send(d, a, b, t, acc);
            exp_edge = (d && b == 32'd0) ? acc : acc + lat + 1;
            wait_wb(60, a, b, seen);
            checks++;
            if (seen != exp_edge) begin
                failures++;
                $display("FAIL rand_latency[%0d]: wb edge=%0d required %0d", n, seen, exp_edge);
            end
            check_result("rand_result", er, ee, t);
            repeat ($urandom_range(0, 3)) @(negedge clock);
            consume();
        end
        checks++;
        if (both_pulses != 0) begin
            failures++;
            $display("FAIL dual_pulse: got %0d cycles with both pulses required 0", both_pulses);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        test_reset();
        test_mult();
        test_divzero();
        test_backpressure();
        test_flush();
        test_timeout();
        test_reset_mid();
        do_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end
endmodule
